// File: rtl/sd_bus_arbiter.sv
// Round-robin arbiter sharing one SD command/data engine among N_REQ sequencers.
// Latency: grant one cycle after request is sampled in IDLE; engine mux and return routing are combinational.
// Backpressure: a holder keeps the engine while req is high; a holder idle for IDLE_LIMIT cycles is forcibly released.
module sd_bus_arbiter #(
  parameter int N_REQ      = 3,
  parameter int IDLE_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      timeout,
  input  logic [N_REQ-1:0]      req_send_cmd_en,
  input  logic [N_REQ-1:0]      req_get_cmd_en,
  input  logic [N_REQ-1:0]      req_get_data_en,
  input  logic [6*N_REQ-1:0]    req_cmd_id,
  input  logic [32*N_REQ-1:0]   req_arg,
  output logic                  send_cmd_en,
  output logic                  get_cmd_en,
  output logic                  get_data_en,
  output logic [5:0]            cmd_id,
  output logic [31:0]           cmd_arg,
  input  logic                  send_cmd_done,
  input  logic                  get_cmd_done,
  input  logic                  get_data_done,
  input  logic                  data_crc_fail,
  output logic [N_REQ-1:0]      req_send_cmd_done,
  output logic [N_REQ-1:0]      req_get_cmd_done,
  output logic [N_REQ-1:0]      req_get_data_done,
  output logic [N_REQ-1:0]      req_data_crc_fail
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (IDLE_LIMIT > 1) ? $clog2(IDLE_LIMIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] timeout_q, timeout_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [N_REQ-1:0] mask_set;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] eligible;
  logic             found;
  logic [PW-1:0]    win_idx;
  int               idx;
  logic             in_grant;
  logic             holder_req;
  logic             activity;

  assign eligible   = req & ~mask_q;
  assign in_grant   = (state_q == S_GRANT);
  assign holder_req = |(gnt_q & req);
  // Engine done flags count as activity even if the holder's own enables are low.
  assign activity   = (|(gnt_q & (req_send_cmd_en | req_get_cmd_en | req_get_data_en)))
                      | send_cmd_done | get_cmd_done | get_data_done;

  // Pick the first eligible requester at or above the pointer, wrapping around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  // Next-state logic: grant, hold/watchdog, and the one-cycle release gap.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = '0;
    mask_set  = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (found) begin
          gnt_d   = N_REQ'(1) << win_idx;
          ptr_d   = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!holder_req) begin
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (activity) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(IDLE_LIMIT - 1)) begin
          timeout_d = gnt_q;
          mask_set  = gnt_q;
          gnt_d     = '0;
          cnt_d     = '0;
          state_d   = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    // A lockout is lifted as soon as its requester lets go of req.
    mask_d = (mask_q & req) | mask_set;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      timeout_q <= '0;
      mask_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Holder's request mux onto the engine and completion routing back to the holder only.
  always_comb begin
    send_cmd_en       = 1'b0;
    get_cmd_en        = 1'b0;
    get_data_en       = 1'b0;
    cmd_id            = '0;
    cmd_arg           = '0;
    req_send_cmd_done = '0;
    req_get_cmd_done  = '0;
    req_get_data_done = '0;
    req_data_crc_fail = '0;
    if (in_grant) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_q[i]) begin
          send_cmd_en          = send_cmd_en | req_send_cmd_en[i];
          get_cmd_en           = get_cmd_en  | req_get_cmd_en[i];
          get_data_en          = get_data_en | req_get_data_en[i];
          cmd_id               = cmd_id  | req_cmd_id[6*i +: 6];
          cmd_arg              = cmd_arg | req_arg[32*i +: 32];
          req_send_cmd_done[i] = send_cmd_done;
          req_get_cmd_done[i]  = get_cmd_done;
          req_get_data_done[i] = get_data_done;
          req_data_crc_fail[i] = data_crc_fail;
        end
      end
    end
  end

  assign gnt     = gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sd_bus_arbiter.sv
module tb_sd_bus_arbiter;

  localparam int N     = 3;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, gnt, timeout;
  logic [N-1:0]  req_send_cmd_en, req_get_cmd_en, req_get_data_en;
  logic [6*N-1:0]  req_cmd_id;
  logic [32*N-1:0] req_arg;
  logic          send_cmd_en, get_cmd_en, get_data_en;
  logic [5:0]    cmd_id;
  logic [31:0]   cmd_arg;
  logic          send_cmd_done, get_cmd_done, get_data_done, data_crc_fail;
  logic [N-1:0]  req_send_cmd_done, req_get_cmd_done, req_get_data_done, req_data_crc_fail;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  sd_bus_arbiter #(.N_REQ(N), .IDLE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .timeout(timeout),
    .req_send_cmd_en(req_send_cmd_en), .req_get_cmd_en(req_get_cmd_en),
    .req_get_data_en(req_get_data_en), .req_cmd_id(req_cmd_id), .req_arg(req_arg),
    .send_cmd_en(send_cmd_en), .get_cmd_en(get_cmd_en), .get_data_en(get_data_en),
    .cmd_id(cmd_id), .cmd_arg(cmd_arg),
    .send_cmd_done(send_cmd_done), .get_cmd_done(get_cmd_done),
    .get_data_done(get_data_done), .data_crc_fail(data_crc_fail),
    .req_send_cmd_done(req_send_cmd_done), .req_get_cmd_done(req_get_cmd_done),
    .req_get_data_done(req_get_data_done), .req_data_crc_fail(req_data_crc_fail)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the engine, whether we sit in the post-release gap,
  // round-robin start point, lockouts and the current run of idle owned cycles.
  int     m_owner = -1;
  bit     m_gap   = 1'b0;
  int     m_ptr   = 0;
  bit     m_lock [N];
  int     m_idle  = 0;
  int     m_to    = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  sel;
    int  c;
    int  lk;
    bit  busy;
    lk = -1;
    if (rst) begin
      m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_idle = 0; m_to = -1;
      for (int j = 0; j < N; j++) m_lock[j] = 1'b0;
    end else begin
      m_to = -1;
      if (m_owner >= 0) begin
        busy = req_send_cmd_en[m_owner] || req_get_cmd_en[m_owner] || req_get_data_en[m_owner]
               || send_cmd_done || get_cmd_done || get_data_done;
        if (!req[m_owner]) begin
          m_owner = -1; m_gap = 1'b1; m_idle = 0;
        end else if (busy) begin
          m_idle = 0;
        end else if (m_idle == LIMIT - 1) begin
          m_to = m_owner; lk = m_owner; m_owner = -1; m_gap = 1'b1; m_idle = 0;
        end else begin
          m_idle = m_idle + 1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else begin
        sel = -1;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (sel < 0 && req[c] === 1'b1 && !m_lock[c]) sel = c;
        end
        if (sel >= 0) begin
          m_owner = sel; m_ptr = (sel + 1) % N; m_idle = 0;
        end
      end
      for (int j = 0; j < N; j++) if (req[j] !== 1'b1) m_lock[j] = 1'b0;
      if (lk >= 0) m_lock[lk] = 1'b1;
    end
  end

  // Every cycle, compare all DUT outputs against what the model says they must be.
  always @(negedge clk) begin
    logic [N-1:0] e_gnt, e_to, e_sd, e_gd, e_dd, e_cf;
    logic e_s, e_g, e_d;
    logic [5:0] e_id;
    logic [31:0] e_arg;
    if (chk_en) begin
      e_gnt = '0; e_to = '0; e_sd = '0; e_gd = '0; e_dd = '0; e_cf = '0;
      e_s = 1'b0; e_g = 1'b0; e_d = 1'b0; e_id = '0; e_arg = '0;
      if (m_owner >= 0) begin
        e_gnt[m_owner] = 1'b1;
        e_s   = req_send_cmd_en[m_owner];
        e_g   = req_get_cmd_en[m_owner];
        e_d   = req_get_data_en[m_owner];
        e_id  = req_cmd_id[6*m_owner +: 6];
        e_arg = req_arg[32*m_owner +: 32];
        e_sd[m_owner] = send_cmd_done;
        e_gd[m_owner] = get_cmd_done;
        e_dd[m_owner] = get_data_done;
        e_cf[m_owner] = data_crc_fail;
      end
      if (m_to >= 0) e_to[m_to] = 1'b1;
      chk("m_gnt", 32'(gnt), 32'(e_gnt));
      chk("m_timeout", 32'(timeout), 32'(e_to));
      chk("m_send_en", 32'(send_cmd_en), 32'(e_s));
      chk("m_getcmd_en", 32'(get_cmd_en), 32'(e_g));
      chk("m_getdata_en", 32'(get_data_en), 32'(e_d));
      chk("m_cmd_id", 32'(cmd_id), 32'(e_id));
      chk("m_cmd_arg", cmd_arg, e_arg);
      chk("m_ret_send", 32'(req_send_cmd_done), 32'(e_sd));
      chk("m_ret_getcmd", 32'(req_get_cmd_done), 32'(e_gd));
      chk("m_ret_data", 32'(req_get_data_done), 32'(e_dd));
      chk("m_ret_crc", 32'(req_data_crc_fail), 32'(e_cf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; req_send_cmd_en = '0; req_get_cmd_en = '0; req_get_data_en = '0;
    req_cmd_id = '0; req_arg = '0;
    send_cmd_done = 1'b0; get_cmd_done = 1'b0; get_data_done = 1'b0; data_crc_fail = 1'b0;
  endtask

  initial begin
    int pd;
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < 3; i++) step();
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_cmd_arg", cmd_arg, 32'h0);
    step(); step();

    // Single requester: one-cycle grant latency, mux and routing to holder 1.
    req[1] = 1'b1; req_send_cmd_en[1] = 1'b1;
    req_cmd_id[11:6] = 6'd17; req_arg[63:32] = 32'h0000_0200;
    @(negedge clk);
    chk("p1_pre_gnt", 32'(gnt), 32'h0);
    step();
    send_cmd_done = 1'b1;
    @(negedge clk);
    chk("p1_gnt", 32'(gnt), 32'b010);
    chk("p1_send_en", 32'(send_cmd_en), 32'h1);
    chk("p1_cmd_id", 32'(cmd_id), 32'd17);
    chk("p1_arg", cmd_arg, 32'h0000_0200);
    chk("p1_ret_send", 32'(req_send_cmd_done), 32'b010);
    step();
    clear_inputs();
    step();
    chk("p1_rel_gnt", 32'(gnt), 32'h0);
    chk("p1_rel_en", 32'(send_cmd_en), 32'h0);
    step(); step();

    // Contention from reset, then fairness: 0 re-requests, 2 still wins next.
    rst = 1'b1; req = 3'b111; req_send_cmd_en = 3'b111;
    req_cmd_id = {6'd3, 6'd2, 6'd1};
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("p2_rst_gnt", 32'(gnt), 32'h0);
    step();
    chk("p2_gnt0", 32'(gnt), 32'b001);
    chk("p2_id0", 32'(cmd_id), 32'd1);
    step();
    req[0] = 1'b0;
    step();
    chk("p2_dead1", 32'({gnt, send_cmd_en}), 32'h0);
    req[0] = 1'b1;
    step();
    chk("p2_dead2", 32'({gnt, send_cmd_en}), 32'h0);
    step();
    chk("p2_gnt1", 32'(gnt), 32'b010);
    req[1] = 1'b0;
    step(); step(); step();
    chk("p2_fair_gnt2", 32'(gnt), 32'b100);
    chk("p2_id2", 32'(cmd_id), 32'd3);
    req[2] = 1'b0;
    step(); step(); step();
    chk("p2_gnt0_again", 32'(gnt), 32'b001);

    // Watchdog: holder 0 sits idle for LIMIT cycles.
    clear_inputs();
    step(); step(); step();
    req[0] = 1'b1;
    step();
    for (int i = 0; i < LIMIT; i++) begin
      chk("p3_hold", 32'(gnt), 32'b001);
      step();
    end
    chk("p3_timeout", 32'(timeout), 32'b001);
    chk("p3_gnt_off", 32'(gnt), 32'h0);
    step();
    chk("p3_timeout_1cyc", 32'(timeout), 32'h0);
    for (int i = 0; i < 4; i++) step();
    chk("p3_locked", 32'(gnt), 32'h0);
    req[0] = 1'b0;
    step();
    req[0] = 1'b1;
    step();
    chk("p3_regrant", 32'(gnt), 32'b001);
    req[0] = 1'b0;
    step(); step();

    // Isolation: holder 1 active, non-holder 2 tries to drive the engine.
    req = 3'b110;
    req_get_cmd_en[1] = 1'b1; req_cmd_id[11:6] = 6'd5;
    req_get_data_en[2] = 1'b1; req_cmd_id[17:12] = 6'd18;
    step();
    get_data_done = 1'b1; data_crc_fail = 1'b1;
    @(negedge clk);
    chk("p4_gnt", 32'(gnt), 32'b010);
    chk("p4_id", 32'(cmd_id), 32'd5);
    chk("p4_data_en", 32'(get_data_en), 32'h0);
    chk("p4_ret_data", 32'(req_get_data_done), 32'b010);
    chk("p4_ret_crc", 32'(req_data_crc_fail), 32'b010);
    step();
    get_data_done = 1'b0; data_crc_fail = 1'b0;

    // Reset during holder 1's CMD18 with get_data_en high.
    req_get_cmd_en[1] = 1'b0; req_get_data_en[1] = 1'b1; req_cmd_id[11:6] = 6'd18;
    @(negedge clk);
    chk("p5_pre_data_en", 32'(get_data_en), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; req = 3'b111;
    @(negedge clk);
    chk("p5_gnt", 32'(gnt), 32'h0);
    chk("p5_en", 32'({send_cmd_en, get_cmd_en, get_data_en}), 32'h0);
    chk("p5_id_arg", 32'(cmd_id) | cmd_arg, 32'h0);
    step();
    chk("p5_ptr0", 32'(gnt), 32'b001);

    // Randomized traffic, alternating busy and quiet segments.
    clear_inputs();
    pd = 3;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 200 == 0) pd = ($urandom_range(0, 1) == 0) ? 3 : 40;
      for (int j = 0; j < N; j++) begin
        if (req[j]) begin
          if ($urandom_range(0, 15) == 0) req[j] = 1'b0;
        end else begin
          if ($urandom_range(0, 7) == 0) req[j] = 1'b1;
        end
        req_send_cmd_en[j] = ($urandom_range(0, pd - 1) == 0);
        req_get_cmd_en[j]  = ($urandom_range(0, pd - 1) == 0);
        req_get_data_en[j] = ($urandom_range(0, pd - 1) == 0);
      end
      req_cmd_id    = 18'($urandom);
      req_arg       = {$urandom, $urandom, $urandom};
      send_cmd_done = ($urandom_range(0, pd) == 0);
      get_cmd_done  = ($urandom_range(0, pd) == 0);
      get_data_done = ($urandom_range(0, pd) == 0);
      data_crc_fail = ($urandom_range(0, 7) == 0);
      rst           = ($urandom_range(0, 499) == 0);
      step();
    end

    rst = 1'b0;
    clear_inputs();
    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
